pulse_monitor: RTL and testbench

PULSE_MONITOR -- requirements
Module: pulse_monitor

---
 rtl/pulse_pkg.sv | 8 +
 rtl/edge_sync.sv | 15 +
 rtl/pulse_monitor.sv | 68 ++++++
 tb/tb_pulse_monitor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg: FSM state encoding and default lost-train timeout for pulse_monitor
package pulse_pkg;
    localparam int DEF_TIMEOUT = 200;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;
    localparam logic [1:0] ST_LOST = 2'd3;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer plus history flop producing one-cycle rise/fall strobes
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;
    always_ff @(posedge clk)
        if (reset) {s1, s2, s3} <= 3'b000;
        else {s1, s2, s3} <= {d, s1, s2};
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
endmodule

// File: rtl/pulse_monitor.sv
// pulse_monitor: measures high time and period of a pulse train, counts rises, flags a lost train
module pulse_monitor
    import pulse_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             signal,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             timeout
);
    logic rise, fall, lapsed;
    logic [1:0] state;
    logic [CNT_W-1:0] ec, ec_inc, hold;
    edge_sync u_sync (.clk(clk), .reset(reset), .d(signal), .rise(rise), .fall(fall));
    // edge counter keeps running through the fall so it measures the whole period at the next rise
    assign ec_inc = (&ec) ? ec : ec + CNT_W'(1);
    assign lapsed = ec >= CNT_W'(TIMEOUT);
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ec      <= '0;
            hold    <= '0;
            width   <= '0;
            period  <= '0;
            count   <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rise) count <= count + CNT_W'(1);
            case (state)
                ST_IDLE: if (rise) begin
                    state <= ST_HIGH;
                    ec    <= CNT_W'(1);
                end
                ST_HIGH: if (fall) begin
                    hold  <= ec;
                    ec    <= ec_inc;
                    state <= ST_LOW;
                end else if (lapsed) begin
                    state   <= ST_LOST;
                    timeout <= 1'b1;
                end else ec <= ec_inc;
                ST_LOW: if (rise) begin
                    period <= ec;
                    width  <= hold;
                    valid  <= 1'b1;
                    ec     <= CNT_W'(1);
                    state  <= ST_HIGH;
                end else if (lapsed) begin
                    state   <= ST_LOST;
                    timeout <= 1'b1;
                end else ec <= ec_inc;
                default: if (rise) begin
                    timeout <= 1'b0;
                    ec      <= CNT_W'(1);
                    state   <= ST_HIGH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: table vectors, hand corner sequences and random stimulus against a timestamp model
module tb_pulse_monitor;
    import pulse_pkg::*;
    localparam int W  = 8;
    localparam int TO = DEF_TIMEOUT;
    localparam int M  = 1 << W;
    logic clk = 1'b0, reset = 1'b1, signal = 1'b0;
    logic [W-1:0] width, period, count;
    logic valid, timeout;
    int errors = 0, checks = 0;
    pulse_monitor #(.CNT_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .signal(signal), .width(width),
        .period(period), .valid(valid), .count(count), .timeout(timeout)
    );
    always #5 clk = ~clk;
    typedef enum {M_IDLE, M_HIGH, M_LOW, M_LOST} mode_t;
    typedef struct {
        bit r; bit s; int w; int p; bit v; int c; bit to;
    } vec_t;
    int t, t_rise, t_fall, m_width, m_period, m_count;
    bit m_valid, m_to;
    mode_t mode;
    bit q[$];
    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask
    // timestamps of detected edges; a rise seen at edge t is the sample taken at edge t-2
    task automatic model(bit s, bit r);
        bit mr, mf;
        if (r) begin
            q = '{0, 0, 0};
            t = 0; mode = M_IDLE;
            m_width = 0; m_period = 0; m_count = 0; m_valid = 0; m_to = 0;
            return;
        end
        t++;
        q.push_back(s);
        if (q.size() > 4) void'(q.pop_front());
        mr = q[1] && !q[0];
        mf = !q[1] && q[0];
        m_valid = 0;
        if (mr) m_count = (m_count + 1) % M;
        case (mode)
            M_IDLE: if (mr) begin mode = M_HIGH; t_rise = t; end
            M_HIGH: if (mf) begin mode = M_LOW; t_fall = t; end
                    else if (t - t_rise >= TO) begin mode = M_LOST; m_to = 1; end
            M_LOW:  if (mr) begin
                        m_width = t_fall - t_rise; m_period = t - t_rise;
                        m_valid = 1; t_rise = t; mode = M_HIGH;
                    end else if (t - t_rise >= TO) begin mode = M_LOST; m_to = 1; end
            M_LOST: if (mr) begin m_to = 0; t_rise = t; mode = M_HIGH; end
        endcase
    endtask
    task automatic step(bit s, bit r, bit chk);
        signal = s; reset = r;
        @(posedge clk);
        model(s, r);
        @(negedge clk);
        if (chk) begin
            check("width", int'(width), m_width % M);
            check("period", int'(period), m_period % M);
            check("valid", int'(valid), int'(m_valid));
            check("count", int'(count), m_count);
            check("timeout", int'(timeout), int'(m_to));
        end
    endtask
    vec_t tbl[20];
    initial begin
        tbl = '{
            '{1,0,0,0,0,0,0}, '{0,1,0,0,0,0,0}, '{0,1,0,0,0,0,0}, '{0,1,0,0,0,1,0},
            '{0,0,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{0,0,0,0,0,1,0},
            '{0,0,0,0,0,1,0}, '{0,1,0,0,0,1,0}, '{0,1,0,0,0,1,0}, '{0,1,3,8,1,2,0},
            '{0,0,3,8,0,2,0}, '{0,0,3,8,0,2,0}, '{0,0,3,8,0,2,0}, '{0,0,3,8,0,2,0},
            '{0,0,3,8,0,2,0}, '{0,1,3,8,0,2,0}, '{0,1,3,8,0,2,0}, '{0,1,3,8,1,3,0}
        };
        // 3 high / 5 low pattern straight from reset
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].r, 0);
            check("tbl_width", int'(width), tbl[i].w);
            check("tbl_period", int'(period), tbl[i].p);
            check("tbl_valid", int'(valid), int'(tbl[i].v));
            check("tbl_count", int'(count), tbl[i].c);
            check("tbl_timeout", int'(timeout), int'(tbl[i].to));
        end
        // lost train: one short pulse then silence
        step(0, 1, 1);
        step(1, 0, 1);
        while (t < TO + 2) step(0, 0, 1);
        check("to_before", int'(timeout), 0);
        step(0, 0, 1);
        check("to_at_200", int'(timeout), 1);
        repeat (3) step(1, 0, 1);
        check("to_clear", int'(timeout), 0);
        check("to_no_valid", int'(valid), 0);
        repeat (4) step(0, 0, 1);
        repeat (3) step(1, 0, 1);
        // reset in the middle of a high phase, signal held high across release
        step(0, 1, 1);
        repeat (4) step(1, 0, 1);
        step(1, 1, 1);
        check("rst_width", int'(width), 0);
        check("rst_period", int'(period), 0);
        check("rst_count", int'(count), 0);
        check("rst_valid", int'(valid), 0);
        repeat (3) step(1, 0, 1);
        check("rst_rise_count", int'(count), 1);
        check("rst_rise_valid", int'(valid), 0);
        repeat (5) step(0, 0, 1);
        repeat (3) step(1, 0, 1);
        // fastest toggle
        step(0, 1, 1);
        for (int i = 0; i < 40; i++) step(i % 2 == 0, 0, 1);
        check("tog_width", int'(width), 1);
        check("tog_period", int'(period), 2);
        // count wrap
        begin
            int n = 0;
            bit s = 0;
            while (count != 8'hff && n < 1000) begin s = !s; step(s, 0, 1); n++; end
            check("wrap_reach_255", int'(count), 255);
            n = 0;
            while (count == 8'hff && n < 8) begin s = !s; step(s, 0, 1); n++; end
            check("wrap_count", int'(count), 0);
            check("wrap_width", int'(width), 1);
            check("wrap_period", int'(period), 2);
            check("wrap_timeout", int'(timeout), 0);
        end
        // random run lengths, some long enough to lose the train, rare resets
        step(0, 1, 1);
        begin
            bit lvl = 0;
            int n = 0;
            while (n < 4000) begin
                int len = ($urandom_range(0, 9) == 0) ? $urandom_range(150, 260) : $urandom_range(1, 10);
                lvl = !lvl;
                for (int k = 0; k < len; k++) step(lvl, $urandom_range(0, 299) == 0, 1);
                n += len;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
